// File: rtl/prf_2d_read_sched_if.sv
// Request/read/response bundle for the 2D-partitioned PRF read-port scheduler.
// The master side drives requests and the stall/flush controls; the slave is the scheduler.
interface prf_2d_read_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 7,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic                      stall_i;
  logic                      flush_i;
  logic                      lo_rd_en_o;
  logic [ADDR_W-1:0]         lo_rd_addr_o;
  logic                      hi_rd_en_o;
  logic [ADDR_W-1:0]         hi_rd_addr_o;
  logic                      lo_vld_o;
  logic                      rsp_valid_o;
  logic [ID_W-1:0]           rsp_id_o;
  logic [ADDR_W-1:0]         rsp_addr_o;

  modport master (
    output req_valid_i, req_addr_i, stall_i, flush_i,
    input  req_ready_o, lo_rd_en_o, lo_rd_addr_o, hi_rd_en_o, hi_rd_addr_o,
           lo_vld_o, rsp_valid_o, rsp_id_o, rsp_addr_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, stall_i, flush_i,
    output req_ready_o, lo_rd_en_o, lo_rd_addr_o, hi_rd_en_o, hi_rd_addr_o,
           lo_vld_o, rsp_valid_o, rsp_id_o, rsp_addr_o
  );
endinterface

// File: rtl/prf_2d_read_sched.sv
// Read-port scheduler for a 2D-partitioned PRF: low-half banks read in the grant cycle, high half one cycle later.
// Define PRF_SCHED_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 7
`endif

module prf_2d_read_sched #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = `SIZE_PHYSICAL_LOG,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  prf_2d_read_sched_if.slave   bus
);

  logic [ADDR_W-1:0]  req_addr [NUM_REQ];
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_vld;
  logic [ID_W-1:0]    gnt_id;
  logic [ADDR_W-1:0]  gnt_addr;
  logic               gnt_en;

  logic               vld_p1;
  logic [ADDR_W-1:0]  addr_p1;
  logic [ID_W-1:0]    id_p1;
  logic               vld_p2;
  logic [ADDR_W-1:0]  addr_p2;
  logic [ID_W-1:0]    id_p2;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_addr[g] = bus.req_addr_i[g*ADDR_W +: ADDR_W];
  end

  // Gating on reset keeps req_ready_o low while reset is held, even with requests pending.
  assign gnt_en = reset & ~bus.stall_i & ~bus.flush_i;

`ifdef PRF_SCHED_RR_EN
  logic [ID_W-1:0] rr_ptr;

  always_comb begin
    logic [ID_W-1:0] idx;
    int              j;
    gnt      = '0;
    gnt_vld  = 1'b0;
    gnt_id   = '0;
    gnt_addr = '0;
    idx      = '0;
    j        = 0;
    if (gnt_en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        j   = (int'(rr_ptr) + k) % NUM_REQ;
        idx = ID_W'(j);
        if (!gnt_vld && bus.req_valid_i[idx]) begin
          gnt_vld  = 1'b1;
          gnt_id   = idx;
          gnt_addr = req_addr[idx];
          gnt[idx] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (gnt_vld) begin
      rr_ptr <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
    end
  end
`else
  always_comb begin
    logic [ID_W-1:0] idx;
    gnt      = '0;
    gnt_vld  = 1'b0;
    gnt_id   = '0;
    gnt_addr = '0;
    idx      = '0;
    if (gnt_en) begin
      // Scan downward so the lowest-index requester is the last, winning, assignment.
      for (int i = NUM_REQ-1; i >= 0; i--) begin
        idx = ID_W'(i);
        if (bus.req_valid_i[idx]) begin
          gnt      = '0;
          gnt_vld  = 1'b1;
          gnt_id   = idx;
          gnt_addr = req_addr[idx];
          gnt[idx] = 1'b1;
        end
      end
    end
  end
`endif

  // G -> S1 -> S2: address/id registers only capture when their valid is captured as 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      id_p1   <= '0;
      vld_p2  <= 1'b0;
      addr_p2 <= '0;
      id_p2   <= '0;
    end else begin
      vld_p1 <= gnt_vld;
      if (gnt_vld) begin
        addr_p1 <= gnt_addr;
        id_p1   <= gnt_id;
      end
      vld_p2 <= vld_p1 & ~bus.flush_i;
      if (vld_p1 && !bus.flush_i) begin
        addr_p2 <= addr_p1;
        id_p2   <= id_p1;
      end
    end
  end

  assign bus.req_ready_o  = gnt;
  assign bus.lo_rd_en_o   = gnt_vld;
  assign bus.lo_rd_addr_o = gnt_addr;
  assign bus.hi_rd_en_o   = vld_p1 & ~bus.flush_i;
  assign bus.hi_rd_addr_o = addr_p1;
  assign bus.lo_vld_o     = vld_p1 & ~bus.flush_i;
  assign bus.rsp_valid_o  = vld_p2 & ~bus.flush_i;
  assign bus.rsp_id_o     = id_p2;
  assign bus.rsp_addr_o   = addr_p2;

endmodule

// File: tb/tb_prf_2d_read_sched.sv
// Table-driven bench for prf_2d_read_sched with a response scoreboard (expected reads queued at grant).
// Arbitration expectations follow PRF_SCHED_RR_EN the same way the design does.
module tb_prf_2d_read_sched;
  localparam int AW = 7;

  typedef struct {
    logic [3:0]         vld;
    logic [3:0][AW-1:0] addr;
    logic               stall;
    logic               flush;
    logic [3:0]         rdy;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [1:0]  id;
    logic [AW-1:0] addr;
  } sb_t;

  logic clk = 1'b0;
  logic reset_n;
  int   n_pass = 0;
  int   n_tot  = 0;
  vec_t tbl[$];
  sb_t  sb[$];
  logic [3:0][AW-1:0] cur_am;
  logic [3:0] arb_exp [5];

  prf_2d_read_sched_if #(.NUM_REQ(4), .ADDR_W(AW)) ifc ();

  prf_2d_read_sched #(.NUM_REQ(4), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic add(input logic [3:0] v, input logic s, input logic f, input logic [3:0] r);
    vec_t e;
    e.vld = v; e.addr = cur_am; e.stall = s; e.flush = f; e.rdy = r;
    tbl.push_back(e);
  endtask

  function automatic logic [1:0] oh2i(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic check_cycle(input int n);
    vec_t v;
    sb_t  e;
    v = tbl[n];
    if (v.flush) begin
      sb.delete();
      chk($sformatf("hi_en_flush[%0d]", n), 32'(ifc.hi_rd_en_o), 0);
      chk($sformatf("lo_vld_flush[%0d]", n), 32'(ifc.lo_vld_o), 0);
      chk($sformatf("rsp_valid_flush[%0d]", n), 32'(ifc.rsp_valid_o), 0);
    end else begin
      if (sb.size() > 0 && sb[0].cyc == n-2) begin
        e = sb.pop_front();
        chk($sformatf("rsp_valid[%0d]", n), 32'(ifc.rsp_valid_o), 1);
        chk($sformatf("rsp_id[%0d]", n), 32'(ifc.rsp_id_o), 32'(e.id));
        chk($sformatf("rsp_addr[%0d]", n), 32'(ifc.rsp_addr_o), 32'(e.addr));
      end else begin
        chk($sformatf("rsp_valid_idle[%0d]", n), 32'(ifc.rsp_valid_o), 0);
      end
      if (sb.size() > 0 && sb[0].cyc == n-1) begin
        chk($sformatf("hi_en[%0d]", n), 32'(ifc.hi_rd_en_o), 1);
        chk($sformatf("hi_addr[%0d]", n), 32'(ifc.hi_rd_addr_o), 32'(sb[0].addr));
        chk($sformatf("lo_vld[%0d]", n), 32'(ifc.lo_vld_o), 1);
      end else begin
        chk($sformatf("hi_en_idle[%0d]", n), 32'(ifc.hi_rd_en_o), 0);
        chk($sformatf("lo_vld_idle[%0d]", n), 32'(ifc.lo_vld_o), 0);
      end
    end
    chk($sformatf("ready[%0d]", n), 32'(ifc.req_ready_o), 32'(v.rdy));
    chk($sformatf("lo_en[%0d]", n), 32'(ifc.lo_rd_en_o), 32'(v.rdy != 4'b0));
    if (v.rdy != 4'b0) begin
      e.cyc  = n;
      e.id   = oh2i(v.rdy);
      e.addr = v.addr[e.id];
      chk($sformatf("lo_addr[%0d]", n), 32'(ifc.lo_rd_addr_o), 32'(e.addr));
      sb.push_back(e);
    end
  endtask

  initial begin
`ifdef PRF_SCHED_RR_EN
    arb_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    arb_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    cur_am = {7'h33, 7'h15, 7'h02, 7'h01};
    add(4'b1111, 0, 0, 4'b0001);                 // first cycle after reset
    add(4'b0000, 0, 0, 4'b0000); add(4'b0000, 0, 0, 4'b0000);
    add(4'b0100, 0, 0, 4'b0100);                 // single read, req 2 @ 0x15
    add(4'b0000, 0, 0, 4'b0000); add(4'b0000, 0, 0, 4'b0000);
    add(4'b0001, 0, 0, 4'b0001);                 // overlap: req 0 then req 1
    add(4'b0010, 0, 0, 4'b0010);
    add(4'b1000, 0, 0, 4'b1000);
    add(4'b0000, 0, 0, 4'b0000);
    cur_am = {7'h7f, 7'h40, 7'h2a, 7'h55};
    for (int k = 0; k < 5; k++) add(4'b1111, 0, 0, arb_exp[k]);
    cur_am = {7'h33, 7'h15, 7'h02, 7'h01};
    add(4'b0000, 0, 0, 4'b0000); add(4'b0000, 0, 0, 4'b0000);
    add(4'b0010, 0, 0, 4'b0010);                 // stall after a grant
    add(4'b0010, 1, 0, 4'b0000);
    add(4'b0010, 0, 0, 4'b0010);
    add(4'b0000, 0, 0, 4'b0000); add(4'b0000, 0, 0, 4'b0000);
    add(4'b0100, 0, 0, 4'b0100);                 // flush after a grant
    add(4'b0101, 0, 1, 4'b0000);
    add(4'b0101, 0, 0, 4'b0001);
    add(4'b0100, 0, 0, 4'b0100);
    add(4'b0000, 0, 0, 4'b0000); add(4'b0000, 0, 0, 4'b0000);
    add(4'b0001, 1, 1, 4'b0000);                 // stall and flush together
    add(4'b0000, 0, 0, 4'b0000);
    add(4'b0001, 0, 0, 4'b0001);                 // flush while the read sits in S2
    add(4'b0000, 0, 0, 4'b0000);
    add(4'b0000, 0, 1, 4'b0000);
    add(4'b0000, 0, 0, 4'b0000); add(4'b0000, 0, 0, 4'b0000);

    reset_n = 1'b0;
    ifc.req_valid_i = 4'b1111;
    ifc.req_addr_i  = cur_am;
    ifc.stall_i     = 1'b0;
    ifc.flush_i     = 1'b0;
    repeat (2) begin
      @(posedge clk); #5;
      chk("rst_ready", 32'(ifc.req_ready_o), 0);
      chk("rst_lo_en", 32'(ifc.lo_rd_en_o), 0);
      chk("rst_hi_en", 32'(ifc.hi_rd_en_o), 0);
      chk("rst_lo_vld", 32'(ifc.lo_vld_o), 0);
      chk("rst_rsp_valid", 32'(ifc.rsp_valid_o), 0);
      chk("rst_rsp_id", 32'(ifc.rsp_id_o), 0);
      chk("rst_rsp_addr", 32'(ifc.rsp_addr_o), 0);
    end

    for (int r = 0; r < tbl.size(); r++) begin
      @(posedge clk); #1;
      reset_n         = 1'b1;
      ifc.req_valid_i = tbl[r].vld;
      ifc.req_addr_i  = tbl[r].addr;
      ifc.stall_i     = tbl[r].stall;
      ifc.flush_i     = tbl[r].flush;
      #4;
      check_cycle(r);
    end
    chk("sb_drained", 32'(sb.size()), 0);

    // Asynchronous reset with a read in flight clears the pipeline immediately.
    @(posedge clk); #1;
    ifc.req_valid_i = 4'b0001;
    #4;
    chk("pre_rst_ready", 32'(ifc.req_ready_o), 32'h1);
    @(posedge clk); #1;
    ifc.req_valid_i = 4'b0010;
    #2;
    chk("pre_rst_hi_en", 32'(ifc.hi_rd_en_o), 1);
    reset_n = 1'b0;
    #1;
    chk("async_ready", 32'(ifc.req_ready_o), 0);
    chk("async_lo_en", 32'(ifc.lo_rd_en_o), 0);
    chk("async_hi_en", 32'(ifc.hi_rd_en_o), 0);
    chk("async_hi_addr", 32'(ifc.hi_rd_addr_o), 0);
    chk("async_lo_vld", 32'(ifc.lo_vld_o), 0);
    @(posedge clk); #1;
    chk("async_rsp_valid", 32'(ifc.rsp_valid_o), 0);
    chk("async_rsp_addr", 32'(ifc.rsp_addr_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
